// File: rtl/hilo_muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hilo_muldiv_pkg
//  Purpose  : Shared constants and types for the HI/LO multiply/divide unit:
//             funct codes, FSM state encoding, step mode and the LO value
//             written on divide-by-zero.
//  Revision : 1.0  initial release
// ============================================================================
package hilo_muldiv_pkg;

  // SPECIAL funct codes of the HI/LO-access instruction class
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  // LO on divide-by-zero; sliced down to the operand width by the user
  localparam logic [63:0] DIV0_LO = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_t;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } step_mode_t;

  // True for every funct this unit consumes; anything else is ignored
  function automatic logic is_hilo_funct(input logic [5:0] funct);
    return funct inside {FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO,
                         FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU};
  endfunction

endpackage
`default_nettype wire

// File: rtl/hilo_muldiv_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : hilo_muldiv_unit_if
//  Purpose  : EXE-stage request/response bundle between the pipeline
//             (master) and the HI/LO multiply/divide unit (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface hilo_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             Valid_IN;
  logic [5:0]       Funct_IN;
  logic [WIDTH-1:0] Operand_A_IN;
  logic [WIDTH-1:0] Operand_B_IN;
  logic             Flush_IN;
  logic             Busy_OUT;
  logic             Stall_OUT;
  logic [WIDTH-1:0] Result_OUT;
  logic [WIDTH-1:0] HI_OUT;
  logic [WIDTH-1:0] LO_OUT;

  modport master (
    output Valid_IN, Funct_IN, Operand_A_IN, Operand_B_IN, Flush_IN,
    input  Busy_OUT, Stall_OUT, Result_OUT, HI_OUT, LO_OUT
  );

  modport slave (
    input  Valid_IN, Funct_IN, Operand_A_IN, Operand_B_IN, Flush_IN,
    output Busy_OUT, Stall_OUT, Result_OUT, HI_OUT, LO_OUT
  );
endinterface
`default_nettype wire

// File: rtl/hilo_muldiv_unit_muldiv_step.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_step
//  Purpose  : One iteration of unsigned shift-add multiply or restoring
//             divide. The accumulator is {upper, lower}:
//               multiply: upper = partial product, lower = multiplier bits
//               divide  : upper = partial remainder, lower = dividend/quotient
//             For divide the new quotient bit is returned separately and the
//             LSB of the next accumulator is left clear for the parent to fill.
//  Revision : 1.0  initial release
// ============================================================================
module muldiv_step
  import hilo_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  step_mode_t         i_mode,
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_operand,
  output logic [2*WIDTH-1:0] o_acc_next,
  output logic               o_q_bit
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_rem_sh;
  logic [WIDTH:0] w_diff;

  // Multiply: add the multiplicand when the current multiplier bit is set
  assign w_sum = {1'b0, i_acc[2*WIDTH-1:WIDTH]}
               + (i_acc[0] ? {1'b0, i_operand} : '0);

  // Divide: shift the next dividend bit into the remainder and trial-subtract;
  // bit WIDTH of the difference is the borrow
  assign w_rem_sh = i_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff   = w_rem_sh - {1'b0, i_operand};

  // Select the iteration result for the active mode
  always_comb begin
    o_acc_next = {w_sum, i_acc[WIDTH-1:1]};
    o_q_bit    = 1'b0;
    if (i_mode == MODE_DIV) begin
      o_q_bit    = ~w_diff[WIDTH];
      o_acc_next = {(o_q_bit ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0]),
                    i_acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule
`default_nettype wire

// File: rtl/hilo_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : hilo_muldiv_unit
//  Purpose  : Execute-stage HI/LO unit. Owns HI and LO, serves MFHI/MFLO/
//             MTHI/MTLO, and runs MULT/MULTU/DIV/DIVU iteratively one bit per
//             cycle (WIDTH ITER cycles + 1 FIX cycle), stalling the pipeline
//             for any HI/LO-class instruction arriving while busy.
//  Revision : 1.0  initial release
// ============================================================================
module hilo_muldiv_unit
  import hilo_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic               CLK,
  input logic               RESET,
  hilo_muldiv_unit_if.slave bus
);

  localparam int              CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(WIDTH - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_count;
  step_mode_t         r_mode;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_op;
  logic               r_neg_q;      // negate product / quotient at FIX
  logic               r_neg_r;      // negate remainder at FIX
  logic               r_div_zero;
  logic [WIDTH-1:0]   r_dividend;   // original dividend, returned in HI on /0
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_known;
  logic               w_busy;
  logic               w_accept;
  logic               w_signed_op;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [2*WIDTH-1:0] w_acc_next;
  logic               w_q_bit;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;

  // Request decode and handshake
  assign w_known  = is_hilo_funct(bus.Funct_IN);
  assign w_busy   = (r_state != IDLE);
  assign w_accept = bus.Valid_IN & w_known & ~w_busy & ~bus.Flush_IN;

  assign bus.Busy_OUT  = w_busy;
  assign bus.Stall_OUT = bus.Valid_IN & w_known & w_busy & ~bus.Flush_IN;
  assign bus.HI_OUT    = r_hi;
  assign bus.LO_OUT    = r_lo;

  // Magnitudes: 0x80..0 maps onto the unsigned value 2^(WIDTH-1) unchanged
  assign w_signed_op = (bus.Funct_IN == FUNCT_MULT) || (bus.Funct_IN == FUNCT_DIV);
  assign w_a_neg     = w_signed_op & bus.Operand_A_IN[WIDTH-1];
  assign w_b_neg     = w_signed_op & bus.Operand_B_IN[WIDTH-1];
  assign w_a_mag     = w_a_neg ? -bus.Operand_A_IN : bus.Operand_A_IN;
  assign w_b_mag     = w_b_neg ? -bus.Operand_B_IN : bus.Operand_B_IN;

  // Sign fix-up applied when leaving FIX
  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quot = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_mode     (r_mode),
    .i_acc      (r_acc),
    .i_operand  (r_op),
    .o_acc_next (w_acc_next),
    .o_q_bit    (w_q_bit)
  );

  // MFHI/MFLO read data, valid only in the cycle the read is accepted
  always_comb begin
    bus.Result_OUT = '0;
    if (w_accept && bus.Funct_IN == FUNCT_MFHI) bus.Result_OUT = r_hi;
    if (w_accept && bus.Funct_IN == FUNCT_MFLO) bus.Result_OUT = r_lo;
  end

  // FSM, iteration datapath registers and architectural HI/LO
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_mode     <= MODE_MUL;
      r_acc      <= '0;
      r_op       <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
      r_dividend <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            case (bus.Funct_IN)
              FUNCT_MTHI: r_hi <= bus.Operand_A_IN;
              FUNCT_MTLO: r_lo <= bus.Operand_A_IN;
              FUNCT_MULT, FUNCT_MULTU: begin
                r_mode  <= MODE_MUL;
                r_acc   <= {{WIDTH{1'b0}}, w_b_mag};
                r_op    <= w_a_mag;
                r_neg_q <= w_a_neg ^ w_b_neg;
                r_neg_r <= 1'b0;
                r_state <= ITER;
                r_count <= '0;
              end
              FUNCT_DIV, FUNCT_DIVU: begin
                r_mode     <= MODE_DIV;
                r_acc      <= {{WIDTH{1'b0}}, w_a_mag};
                r_op       <= w_b_mag;
                r_neg_q    <= w_a_neg ^ w_b_neg;
                r_neg_r    <= w_a_neg;
                r_div_zero <= (bus.Operand_B_IN == '0);
                r_dividend <= bus.Operand_A_IN;
                r_state    <= ITER;
                r_count    <= '0;
              end
              default: ;
            endcase
          end
        end
        ITER: begin
          if (bus.Flush_IN) begin
            r_state <= IDLE;
            r_count <= '0;
          end else begin
            r_acc <= w_acc_next | {{(2*WIDTH-1){1'b0}}, w_q_bit};
            if (r_count == C_LAST) begin
              r_state <= FIX;
              r_count <= '0;
            end else begin
              r_count <= r_count + 1'b1;
            end
          end
        end
        FIX: begin
          r_state <= IDLE;
          if (!bus.Flush_IN) begin
            if (r_mode == MODE_MUL) begin
              r_hi <= w_prod[2*WIDTH-1:WIDTH];
              r_lo <= w_prod[WIDTH-1:0];
            end else if (r_div_zero) begin
              r_hi <= r_dividend;
              r_lo <= DIV0_LO[WIDTH-1:0];
            end else begin
              r_hi <= w_rem;
              r_lo <= w_quot;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hilo_muldiv_unit
//  Purpose  : Directed self-checking bench for hilo_muldiv_unit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hilo_muldiv_unit;
  import hilo_muldiv_pkg::*;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  hilo_muldiv_unit_if #(.WIDTH(32)) bus ();

  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run can never hang
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.Valid_IN     = 1'b0;
    bus.Funct_IN     = 6'h00;
    bus.Operand_A_IN = '0;
    bus.Operand_B_IN = '0;
    bus.Flush_IN     = 1'b0;
  endtask

  task automatic present(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    bus.Valid_IN     = 1'b1;
    bus.Funct_IN     = f;
    bus.Operand_A_IN = a;
    bus.Operand_B_IN = b;
    #1;
  endtask

  // Present for one edge (accepted if the unit is idle), then drop the request
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    present(f, a, b);
    tick();
    idle_inputs();
  endtask

  // Count Busy cycles of an operation accepted on the previous edge
  task automatic wait_done(input string tag);
    int n = 0;
    while (bus.Busy_OUT && n < 100) begin
      tick();
      n++;
    end
    check(tag, n, 33);
  endtask

  // Count cycles a held request is stalled
  task automatic count_stall(input string tag);
    int n = 0;
    while (bus.Stall_OUT && n < 100) begin
      tick();
      n++;
    end
    check(tag, n, 33);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    idle_inputs();
    repeat (3) tick();
    check("reset_hi", bus.HI_OUT, 32'h0);
    check("reset_lo", bus.LO_OUT, 32'h0);
    check("reset_busy", {31'b0, bus.Busy_OUT}, 32'h0);
    check("reset_stall", {31'b0, bus.Stall_OUT}, 32'h0);
    check("reset_result", bus.Result_OUT, 32'h0);
    rst = 1'b0;
    tick();

    // MULT -1 * 7
    issue(FUNCT_MULT, 32'hFFFFFFFF, 32'd7);
    check("mult_busy_start", {31'b0, bus.Busy_OUT}, 32'h1);
    wait_done("mult_busy_cycles");
    check("mult_hi", bus.HI_OUT, 32'hFFFFFFFF);
    check("mult_lo", bus.LO_OUT, 32'hFFFFFFF9);

    // MULTU same operands; also an unrecognised funct while busy must not stall
    issue(FUNCT_MULTU, 32'hFFFFFFFF, 32'd7);
    present(6'h20, 32'h1, 32'h1);
    check("unknown_no_stall", {31'b0, bus.Stall_OUT}, 32'h0);
    idle_inputs();
    wait_done("multu_busy_cycles");
    check("multu_hi", bus.HI_OUT, 32'h00000006);
    check("multu_lo", bus.LO_OUT, 32'hFFFFFFF9);

    // DIV -7 / 2
    issue(FUNCT_DIV, 32'hFFFFFFF9, 32'd2);
    wait_done("div_busy_cycles");
    check("div_lo", bus.LO_OUT, 32'hFFFFFFFD);
    check("div_hi", bus.HI_OUT, 32'hFFFFFFFF);

    // DIVU 7 / 0
    issue(FUNCT_DIVU, 32'd7, 32'd0);
    wait_done("divu0_busy_cycles");
    check("divu0_hi", bus.HI_OUT, 32'h00000007);
    check("divu0_lo", bus.LO_OUT, 32'hFFFFFFFF);

    // MULT -2 * 3, MFLO held the next cycle
    issue(FUNCT_MULT, 32'hFFFFFFFE, 32'd3);
    present(FUNCT_MFLO, 32'h0, 32'h0);
    check("mflo_stall_first", {31'b0, bus.Stall_OUT}, 32'h1);
    count_stall("mflo_stall_cycles");
    check("mflo_result", bus.Result_OUT, 32'hFFFFFFFA);
    tick();
    idle_inputs();
    check("mult2_hi", bus.HI_OUT, 32'hFFFFFFFF);

    // MTHI then MFHI with no stall
    issue(FUNCT_MTHI, 32'h12345678, 32'h0);
    present(FUNCT_MFHI, 32'h0, 32'h0);
    check("mfhi_no_stall", {31'b0, bus.Stall_OUT}, 32'h0);
    check("mfhi_result", bus.Result_OUT, 32'h12345678);
    tick();
    idle_inputs();
    #1;
    check("result_idle_zero", bus.Result_OUT, 32'h0);

    // MTLO while busy: lands after the multiply result
    issue(FUNCT_MULT, 32'd2, 32'd3);
    present(FUNCT_MTLO, 32'hAABBCCDD, 32'h0);
    count_stall("mtlo_stall_cycles");
    check("mtlo_mult_lo_before", bus.LO_OUT, 32'h00000006);
    tick();
    idle_inputs();
    check("mtlo_final_lo", bus.LO_OUT, 32'hAABBCCDD);
    check("mtlo_mult_hi", bus.HI_OUT, 32'h00000000);

    // Known HI/LO, then flush a DIV in ITER cycle 10
    issue(FUNCT_MTHI, 32'h11111111, 32'h0);
    issue(FUNCT_MTLO, 32'h22222222, 32'h0);
    issue(FUNCT_DIV, 32'd100, 32'd7);
    repeat (10) tick();
    bus.Flush_IN = 1'b1;
    present(FUNCT_MFHI, 32'h0, 32'h0);
    check("flush_no_stall", {31'b0, bus.Stall_OUT}, 32'h0);
    tick();
    idle_inputs();
    check("flush_iter_busy", {31'b0, bus.Busy_OUT}, 32'h0);
    repeat (40) tick();
    check("flush_iter_hi", bus.HI_OUT, 32'h11111111);
    check("flush_iter_lo", bus.LO_OUT, 32'h22222222);

    // Flush in the FIX cycle suppresses the write
    issue(FUNCT_DIV, 32'd100, 32'd7);
    repeat (32) tick();
    check("fix_busy", {31'b0, bus.Busy_OUT}, 32'h1);
    bus.Flush_IN = 1'b1;
    tick();
    idle_inputs();
    check("flush_fix_busy", {31'b0, bus.Busy_OUT}, 32'h0);
    check("flush_fix_hi", bus.HI_OUT, 32'h11111111);
    check("flush_fix_lo", bus.LO_OUT, 32'h22222222);

    // Reset mid-ITER
    issue(FUNCT_MULT, 32'd5, 32'd5);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_hi", bus.HI_OUT, 32'h0);
    check("rst_mid_lo", bus.LO_OUT, 32'h0);
    check("rst_mid_busy", {31'b0, bus.Busy_OUT}, 32'h0);
    tick();

    // DIV most-negative / -1 wraps
    issue(FUNCT_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done("divmin_busy_cycles");
    check("divmin_lo", bus.LO_OUT, 32'h80000000);
    check("divmin_hi", bus.HI_OUT, 32'h00000000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Execute-stage unit that consumes the decoder's HI/LO-access class of instructions: MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
- Owns the architectural HI and LO registers.
- Runs multiply and divide iteratively at one bit per cycle.
- Stalls the pipeline when an instruction that needs HI/LO, or a new mult/div, arrives while an operation is still in flight.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
- CLK  in  1  single clock.
- RESET  in  1  synchronous, active-high reset.
- Valid_IN  in  1  EXE holds a HI/LO-class instruction this cycle.
- Funct_IN  in  6  SPECIAL funct field of that instruction.
- Operand_A_IN  in  WIDTH  rs value (multiplicand / dividend / MTHI / MTLO source).
- Operand_B_IN  in  WIDTH  rt value (multiplier / divisor).
- Flush_IN  in  1  squash any in-flight op and the current request.
- Busy_OUT  out  1  mult/div iteration in progress.
- Stall_OUT  out  1  pipeline must hold EXE and earlier stages.
- Result_OUT  out  WIDTH  MFHI/MFLO read data.
- HI_OUT  out  WIDTH  current HI.
- LO_OUT  out  WIDTH  current LO.

Behaviour:
- Reset: HI=0, LO=0, state=IDLE, counter=0. Busy_OUT=0, Stall_OUT=0, Result_OUT=0. Reset mid-operation discards the operation.
- Funct codes: MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B. Any other funct with Valid_IN=1 is ignored and causes no stall.
- Stall_OUT (combinational) = Valid_IN & recognised funct & Busy_OUT & ~Flush_IN. A stalled request is held by the pipeline and accepted on the first cycle Busy_OUT=0.
- Accept condition: Valid_IN & recognised & ~Busy_OUT & ~Flush_IN.
- MTHI/MTLO on accept: HI (or LO) <= Operand_A_IN at the next edge.
- MFHI/MFLO on accept: Result_OUT = HI (or LO), combinational, same cycle. Otherwise Result_OUT = 0.
- MULT/MULTU/DIV/DIVU on accept: operands latched at the edge, state IDLE -> ITER with counter=0.
- State machine IDLE -> ITER -> FIX -> IDLE:
  - ITER lasts exactly WIDTH cycles.
  - Multiply: shift-add on operand magnitudes.
  - Divide: restoring divide on magnitudes.
  - FIX lasts 1 cycle: applies signs and writes HI and LO at the end of FIX.
  - Busy_OUT=1 in ITER and FIX, i.e. 33 cycles for WIDTH=32.
  - The first instruction able to read the new HI/LO is accepted on the cycle after FIX.
- Signed ops (MULT/DIV) operate on magnitudes; signed-ness is recorded at accept.
  - MULT: {HI,LO} = 64-bit two's-complement product.
  - DIV: quotient is negated when operand signs differ. Remainder takes the sign of the dividend.
- Unsigned ops (MULTU/DIVU) skip sign handling.
- Mult: HI = product[63:32], LO = product[31:0]. Div: LO = quotient, HI = remainder.
- Boundary conditions:
  - 0x80000000 is handled via unsigned magnitude 2^31.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (wraps, no trap).
  - Divide by zero, signed or unsigned: HI=dividend (original, signed value), LO=0xFFFFFFFF. No exception.
- Flush_IN: has priority over Valid_IN. In ITER or FIX it returns to IDLE at the next edge, and HI/LO are unchanged. Flush in the FIX cycle suppresses the write.
- No overlap: a new mult/div is never accepted while Busy_OUT=1, so the stall is mandatory.

Decomposition:
- Package hilo_muldiv_pkg holds:
  - funct constants (FUNCT_MFHI … FUNCT_DIVU);
  - state encoding (IDLE, ITER, FIX);
  - the DIV0_LO constant (all ones).
- Sub-module muldiv_step: combinational one-iteration datapath.
  - Inputs: mode, partial accumulator, shifted operand.
  - Outputs: next accumulator and quotient bit.
  - The parent owns the FSM, counter, sign fix-up and HI/LO.

Test Plan:
- MULT A=0xFFFFFFFF, B=7 -> Busy 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF9; MULTU with the same operands -> HI=0x00000006, LO=0xFFFFFFF9.
- DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=7, B=0 -> HI=0x00000007, LO=0xFFFFFFFF.
- MULT then MFLO presented on the next cycle -> Stall_OUT=1 for 33 cycles, then MFLO accepted and Result_OUT=LO of the product in that cycle.
- MTHI A=0x12345678 then MFHI -> no stall, Result_OUT=0x12345678; MTLO while Busy -> stalled until Busy falls, and the final LO equals the MTLO value, not the mult result.
- DIV started, Flush_IN asserted in ITER cycle 10 (and separately in the FIX cycle) -> IDLE next cycle, HI/LO retain their prior values, Busy_OUT=0.
- RESET asserted mid-ITER -> HI=LO=0, Busy_OUT=0 next cycle; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
